adder_8: RTL and testbench

//   8-bit ripple-carry adder/subtractor with registered outputs.

---
 rtl/adder_8_if.sv | 25 ++
 rtl/adder_8.sv | 39 +++
 tb/tb_adder_8.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/adder_8_if.sv
// Operand/result bundle for the registered 8-bit adder/subtractor.
// The master drives operands and mode; the slave returns the registered result.
interface adder_8_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic [7:0] y;
    logic       carry;

    modport master (
        output a,
        output b,
        output carry_in,
        input  y,
        input  carry
    );

    modport slave (
        input  a,
        input  b,
        input  carry_in,
        output y,
        output carry
    );
endinterface

// File: rtl/adder_8.sv
// 8-bit ripple-carry adder/subtractor with a single output register stage.
// carry_in selects the mode: 0 adds, 1 subtracts by inverting B and injecting a carry.
module adder_8 (
    input  logic      clk,
    input  logic      rst,
    adder_8_if.slave  bus
);

    localparam int WIDTH = 8;

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;

    assign w_bx   = bus.b ^ {WIDTH{bus.carry_in}};
    assign w_c[0] = bus.carry_in;

    // Explicit full-adder chain so the carry path is the classic ripple structure.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign w_sum[i]  = bus.a[i] ^ w_bx[i] ^ w_c[i];
        assign w_c[i+1]  = (bus.a[i] & w_bx[i]) | (w_c[i] & (bus.a[i] ^ w_bx[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= '0;
            r_carry <= 1'b0;
        end else begin
            r_y     <= w_sum;
            r_carry <= w_c[WIDTH];
        end
    end

    assign bus.y     = r_y;
    assign bus.carry = r_carry;

endmodule

// File: tb/tb_adder_8.sv
// Self-checking bench for adder_8: a queue scoreboard holds expected {carry,y} per driven vector.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_adder_8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adder_8_if bus ();

    adder_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [8:0] sb[$];

    // Reference: subtraction as a + 256 - b keeps the no-borrow flag in bit 8.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
        int t;
        if (m) t = int'(a) + 256 - int'(b);
        else   t = int'(a) + int'(b);
        return t[8:0];
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic m);
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = m;
        sb.push_back(model(a, b, m));
    endtask

    task automatic checkOutput(input string tag);
        logic [8:0] expv;
        logic [8:0] obs;
        @(posedge clk);
        #1;
        total++;
        obs = {bus.carry, bus.y};
        if (sb.size() == 0) begin
            bad++;
            $error("[TB] FAIL %s: actual={carry,y}=%h required=a queued result (scoreboard empty)", tag, obs);
        end else begin
            expv = sb.pop_front();
            assert (obs === expv) else begin
                bad++;
                $error("[TB] FAIL %s: actual={carry,y}=%h required=%h", tag, obs, expv);
            end
        end
    endtask

    task automatic checkZero(input string tag);
        logic [8:0] obs;
        total++;
        obs = {bus.carry, bus.y};
        assert (obs === 9'h000) else begin
            bad++;
            $error("[TB] FAIL %s: actual={carry,y}=%h required=000", tag, obs);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.a        = 8'hAA;
        bus.b        = 8'h55;
        bus.carry_in = 1'b0;

        // Reset held with operands present and clock running
        #1;
        checkZero("reset_immediate");
        repeat (3) @(posedge clk);
        #1;
        checkZero("reset_hold");

        // First edge after release loads AA+55
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(8'hAA, 8'h55, 1'b0));
        checkOutput("reset_first_load");

        // Directed add / subtract
        applyStimulus(8'd5, 8'd5, 1'b0);     checkOutput("add_5_5");
        applyStimulus(8'd8, 8'd5, 1'b0);     checkOutput("add_8_5");
        applyStimulus(8'd8, 8'd5, 1'b1);     checkOutput("sub_8_5");
        applyStimulus(8'd5, 8'd8, 1'b1);     checkOutput("sub_5_8");

        // Wrap and boundary cases
        applyStimulus(8'hFF, 8'h01, 1'b0);   checkOutput("add_ff_01");
        applyStimulus(8'hFF, 8'hFF, 1'b0);   checkOutput("add_ff_ff");
        applyStimulus(8'h80, 8'h80, 1'b1);   checkOutput("sub_80_80");
        applyStimulus(8'h3C, 8'h00, 1'b1);   checkOutput("sub_b_zero");
        applyStimulus(8'h00, 8'h01, 1'b1);   checkOutput("sub_0_1");
        applyStimulus(8'h00, 8'h00, 1'b0);   checkOutput("add_0_0");
        applyStimulus(8'h7F, 8'h01, 1'b0);   checkOutput("add_7f_01");

        // Back-to-back vectors, one per cycle
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i * 17 + 3), 8'(i * 29 + 11), i[0]);
            checkOutput("throughput");
        end

        // Async reset between edges clears outputs, and the pending vector is discarded
        applyStimulus(8'h12, 8'h34, 1'b0);
        checkOutput("pre_reset");
        #2;
        rst = 1'b1;
        #1;
        checkZero("async_reset");
        @(negedge clk);
        bus.a        = 8'hC3;
        bus.b        = 8'h21;
        bus.carry_in = 1'b0;
        @(posedge clk);
        #1;
        checkZero("reset_discard");
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("[TB] FAIL sb_empty: actual=%0d entries required=0", sb.size());
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(8'hC3, 8'h21, 1'b0));
        checkOutput("post_reset_load");

        // Random vectors in both modes
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            checkOutput("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
